// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcode encodings, the link
// register number and the sequencer state type.
package wb_pkg;

  localparam int WB_RF_ADDR_W = 4;
  localparam int WB_DATA_W    = 32;
  localparam logic [3:0] WB_LINK_REG = 4'd14;

  // 5'h00-5'h0F are plain ALU operations
  localparam logic [4:0] OP_LDR  = 5'h10;
  localparam logic [4:0] OP_STR  = 5'h11;
  localparam logic [4:0] OP_CMP  = 5'h12;
  localparam logic [4:0] OP_TST  = 5'h13;
  localparam logic [4:0] OP_CMN  = 5'h14;
  localparam logic [4:0] OP_ADDS = 5'h15;
  localparam logic [4:0] OP_SUBS = 5'h16;

  typedef enum logic {
    IDLE         = 1'b0,
    LINK_PENDING = 1'b1
  } wb_state_t;

  function automatic logic is_flag_op(input logic [4:0] op);
    return (op == OP_CMP) || (op == OP_TST) || (op == OP_CMN) ||
           (op == OP_ADDS) || (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/wb_data_select.sv
// Chooses load data or ALU result as the writeback value and flags the
// opcodes that update the architectural NZCV register.
module wb_data_select
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_op
);

  always_comb begin
    wb_data = (opcode == OP_LDR) ? mem_data : alu_data;
    flag_op = is_flag_op(opcode);
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Writeback stage: drives the single-port register file, splitting
// link-with-writeback instructions into two consecutive writes.
module writeback_sequencer
  import wb_pkg::*;
#(
  parameter int              RF_ADDR_W = WB_RF_ADDR_W,
  parameter int              DATA_W    = WB_DATA_W,
  parameter logic [RF_ADDR_W-1:0] LINK_REG = WB_LINK_REG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    dataMemOut_in,
  input  logic [DATA_W-1:0]    writeData_in,
  input  logic [DATA_W-1:0]    data2_in,
  input  logic [RF_ADDR_W-1:0] rd_in,
  input  logic                 linkBit_in,
  input  logic                 writebackEnable_in,
  input  logic [3:0]           CPSRStatus_in,
  input  logic [4:0]           opcode_in,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [3:0]           cpsr_flags,
  output logic                 stall_out,
  output logic                 protocol_error,
  output logic [31:0]          retired_count
);

  logic [DATA_W-1:0] sel_data;
  logic              flag_op;

  wb_data_select #(.DATA_W(DATA_W)) u_data_select (
    .opcode   (opcode_in),
    .mem_data (dataMemOut_in),
    .alu_data (writeData_in),
    .wb_data  (sel_data),
    .flag_op  (flag_op)
  );

  wb_state_t             state_reg, state_next;
  logic [DATA_W-1:0]     pending_reg, pending_next;
  logic                  we_next;
  logic [RF_ADDR_W-1:0]  waddr_next;
  logic [DATA_W-1:0]     wdata_next;
  logic                  perr_next;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    we_next      = 1'b0;
    waddr_next   = rf_waddr;
    wdata_next   = rf_wdata;
    perr_next    = protocol_error;
    stall_out    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (writebackEnable_in && linkBit_in) begin
          // rd goes first; the link value waits one cycle in pending_reg
          stall_out    = 1'b1;
          we_next      = 1'b1;
          waddr_next   = rd_in;
          wdata_next   = sel_data;
          pending_next = data2_in;
          state_next   = LINK_PENDING;
        end else if (writebackEnable_in) begin
          we_next    = 1'b1;
          waddr_next = rd_in;
          wdata_next = sel_data;
        end else if (linkBit_in) begin
          we_next    = 1'b1;
          waddr_next = LINK_REG;
          wdata_next = data2_in;
        end
      end
      LINK_PENDING: begin
        // Upstream should be presenting a bubble; anything else is lost.
        we_next    = 1'b1;
        waddr_next = LINK_REG;
        wdata_next = pending_reg;
        state_next = IDLE;
        if (writebackEnable_in || linkBit_in) begin
          perr_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      cpsr_flags     <= '0;
      protocol_error <= 1'b0;
      retired_count  <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      rf_we          <= we_next;
      rf_waddr       <= waddr_next;
      rf_wdata       <= wdata_next;
      protocol_error <= perr_next;
      retired_count  <= retired_count + {31'd0, we_next};
      if (flag_op) begin
        cpsr_flags <= CPSRStatus_in;
      end
    end
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Scoreboarded bench: the driver predicts each cycle's outcome from the
// instruction-level rules and queues it; a negedge monitor checks the DUT.
module tb_writeback_sequencer;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataMemOut_in = '0;
  logic [31:0] writeData_in = '0;
  logic [31:0] data2_in = '0;
  logic [3:0]  rd_in = '0;
  logic        linkBit_in = 1'b0;
  logic        writebackEnable_in = 1'b0;
  logic [3:0]  CPSRStatus_in = '0;
  logic [4:0]  opcode_in = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  cpsr_flags;
  logic        stall_out;
  logic        protocol_error;
  logic [31:0] retired_count;

  writeback_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .dataMemOut_in      (dataMemOut_in),
    .writeData_in       (writeData_in),
    .data2_in           (data2_in),
    .rd_in              (rd_in),
    .linkBit_in         (linkBit_in),
    .writebackEnable_in (writebackEnable_in),
    .CPSRStatus_in      (CPSRStatus_in),
    .opcode_in          (opcode_in),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .cpsr_flags         (cpsr_flags),
    .stall_out          (stall_out),
    .protocol_error     (protocol_error),
    .retired_count      (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_reset;
    bit          we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  cpsr;
    logic [31:0] cnt;
    bit          perr;
  } exp_t;

  typedef struct {
    int due;
    bit val;
  } stall_t;

  exp_t   out_q[$];
  stall_t stall_q[$];
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;

  // Reference state: what the architecture owes, not how the RTL holds it
  bit          m_owes_link = 0;
  logic [31:0] m_link_val = '0;
  bit          m_perr = 0;
  logic [31:0] m_cnt = '0;
  logic [3:0]  m_cpsr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input bit rst, input logic [4:0] opc, input bit wb, input bit lk,
                       input logic [3:0] rd, input logic [31:0] wd, input logic [31:0] dm,
                       input logic [31:0] d2, input logic [3:0] st);
    exp_t   e;
    stall_t s;
    @(posedge clk);
    #1;
    reset = rst; opcode_in = opc; writebackEnable_in = wb; linkBit_in = lk;
    rd_in = rd; writeData_in = wd; dataMemOut_in = dm; data2_in = d2; CPSRStatus_in = st;
    e.due = cyc + 1; e.is_reset = rst; e.we = 0; e.waddr = '0; e.wdata = '0;
    if (rst) begin
      m_owes_link = 0; m_perr = 0; m_cnt = '0; m_cpsr = '0;
    end else begin
      s.due = cyc; s.val = !m_owes_link && wb && lk;
      stall_q.push_back(s);
      if (m_owes_link) begin
        e.we = 1; e.waddr = 4'd14; e.wdata = m_link_val;
        m_owes_link = 0;
        if (wb || lk) m_perr = 1;
      end else if (wb) begin
        e.we = 1; e.waddr = rd; e.wdata = (opc == 5'h10) ? dm : wd;
        if (lk) begin
          m_owes_link = 1; m_link_val = d2;
        end
      end else if (lk) begin
        e.we = 1; e.waddr = 4'd14; e.wdata = d2;
      end
      if (opc >= 5'h12 && opc <= 5'h16) m_cpsr = st;
      if (e.we) m_cnt = m_cnt + 1;
    end
    e.cpsr = m_cpsr; e.cnt = m_cnt; e.perr = m_perr;
    out_q.push_back(e);
  endtask

  task automatic bubble();
    drive(0, 5'h00, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0);
  endtask

  always @(negedge clk) begin
    while (stall_q.size() > 0 && stall_q[0].due == cyc) begin
      vectors++;
      if (stall_out !== stall_q[0].val) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got=%0b exp=%0b", cyc, stall_out, stall_q[0].val);
      end
      void'(stall_q.pop_front());
    end
    while (out_q.size() > 0 && out_q[0].due == cyc) begin
      exp_t e;
      e = out_q.pop_front();
      vectors++;
      if (rf_we !== e.we) begin
        miscompares++;
        $display("FAIL rf_we cyc=%0d got=%0b exp=%0b", cyc, rf_we, e.we);
      end
      if ((e.we || e.is_reset) && (rf_waddr !== e.waddr || rf_wdata !== e.wdata)) begin
        miscompares++;
        $display("FAIL rf_write cyc=%0d got=R%0d:%h exp=R%0d:%h", cyc, rf_waddr, rf_wdata,
                 e.waddr, e.wdata);
      end
      if (cpsr_flags !== e.cpsr) begin
        miscompares++;
        $display("FAIL cpsr cyc=%0d got=%b exp=%b", cyc, cpsr_flags, e.cpsr);
      end
      if (retired_count !== e.cnt) begin
        miscompares++;
        $display("FAIL retired cyc=%0d got=%0d exp=%0d", cyc, retired_count, e.cnt);
      end
      if (protocol_error !== e.perr) begin
        miscompares++;
        $display("FAIL protocol_error cyc=%0d got=%0b exp=%0b", cyc, protocol_error, e.perr);
      end
      $display("cyc=%0d we=%0b R%0d=%h cpsr=%b cnt=%0d perr=%0b", cyc, rf_we, rf_waddr,
               rf_wdata, cpsr_flags, retired_count, protocol_error);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 5'h00, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    drive(1, 5'h00, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    drive(0, 5'h04, 1, 0, 4'd3, 32'h11, 32'h0, 32'h0, 4'd0);
    drive(0, OP_LDR, 1, 0, 4'd5, 32'h7, 32'hDEADBEEF, 32'h0, 4'd0);
    drive(0, 5'h01, 0, 1, 4'd9, 32'h5, 32'h0, 32'h200, 4'd0);
    drive(0, 5'h02, 1, 1, 4'd2, 32'hA, 32'h0, 32'h104, 4'd0);
    bubble();
    drive(0, 5'h02, 1, 1, 4'd14, 32'hA, 32'h0, 32'h104, 4'd0);
    bubble();
    drive(0, OP_CMP, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 4'b0110);
    drive(0, 5'h04, 1, 0, 4'd1, 32'h33, 32'h0, 32'h0, 4'b1111);
    drive(0, OP_SUBS, 1, 1, 4'd7, 32'h77, 32'h0, 32'h88, 4'b1001);
    drive(0, 5'h03, 1, 0, 4'd6, 32'h66, 32'h0, 32'h0, 4'd0);
    bubble();
    bubble();
    drive(0, 5'h02, 1, 1, 4'd4, 32'h44, 32'h0, 32'h144, 4'd0);
    drive(1, 5'h00, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    bubble();
    bubble();

    for (int i = 0; i < 2000; i++) begin
      bit rst, wb, lk;
      rst = ($urandom_range(0, 99) < 2);
      if (m_owes_link && $urandom_range(0, 15) != 0) begin
        wb = 0; lk = 0;
      end else begin
        wb = 1'($urandom_range(0, 1));
        lk = 1'($urandom_range(0, 1));
      end
      drive(rst, 5'($urandom_range(0, 31)), wb, lk, 4'($urandom_range(0, 15)), $urandom,
            $urandom, $urandom, 4'($urandom_range(0, 15)));
    end

    bubble();
    bubble();
    @(posedge clk);
    @(posedge clk);
    #2;
    if (out_q.size() != 0 || stall_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d pending exp=0", out_q.size(), stall_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
